// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand-entry sequencer: state codes,
// LED phase width and the default operand/opcode widths used by the ALU top.
package alu_seq_pkg;

    localparam int PHASE_W       = 3;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_OPW   = 4;

    // State codes are fixed because they are shown directly on the phase LEDs.
    typedef enum logic [PHASE_W-1:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SHOW   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Clear/enable/expire counter guarding the WAIT state of the sequencer.
// Only present when SEQ_WATCHDOG_EN is defined.
`ifdef SEQ_WATCHDOG_EN
module seq_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on clear, advance while enabled, hold at the last step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires in the LIMIT-th enabled cycle after a clear.
    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/alu_operand_sequencer.sv
// Operand-entry sequencer: captures operand A, operand B and opcode from the
// switch bank on successive debounced presses, starts the ALU, waits for it
// and holds the result phase for display.
// Optional feature macro: SEQ_WATCHDOG_EN (WAIT timeout -> SHOW with err=1).
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int OPW        = DEFAULT_OPW,
    parameter int WAIT_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   sw,
    input  logic               next_p,
    input  logic               clr_p,
    input  logic               alu_done,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic [OPW-1:0]     opcode,
    output logic               alu_start,
    output logic               busy,
    output logic [PHASE_W-1:0] phase,
    output logic               err
);

    seq_state_e       state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [OPW-1:0]   opcode_q;
    logic             wd_expire_s;

`ifdef SEQ_WATCHDOG_EN
    logic err_q;

    // The counter restarts while in ISSUE (the only way into WAIT) and on clear.
    seq_watchdog #(
        .LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    ((state_q == ST_ISSUE) || clr_p),
        .en_i     (state_q == ST_WAIT),
        .expire_o (wd_expire_s)
    );

    assign err = err_q;
`else
    assign wd_expire_s = 1'b0;
    assign err         = 1'b0;
`endif

    // Sequencer FSM: state transitions and operand/opcode capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_GET_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
`ifdef SEQ_WATCHDOG_EN
            err_q    <= 1'b0;
`endif
        end else if (clr_p) begin
            // Clear beats a simultaneous next press: nothing is captured.
            state_q  <= ST_GET_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
`ifdef SEQ_WATCHDOG_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_GET_A: begin
                    if (next_p) begin
                        op_a_q  <= sw;
                        state_q <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (next_p) begin
                        op_b_q  <= sw;
                        state_q <= ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (next_p) begin
                        opcode_q <= sw[OPW-1:0];
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Presses and done pulses in this cycle are dropped.
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        state_q <= ST_SHOW;
                    end else if (wd_expire_s) begin
                        state_q <= ST_SHOW;
`ifdef SEQ_WATCHDOG_EN
                        err_q   <= 1'b1;
`endif
                    end
                end
                ST_SHOW: begin
                    if (next_p) begin
                        state_q <= ST_GET_A;
`ifdef SEQ_WATCHDOG_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_GET_A;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign alu_start = (state_q == ST_ISSUE);
    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign phase     = state_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign opcode    = opcode_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer. Expected operand sets are
// queued when the third press is driven and checked when alu_start appears.
module tb_alu_operand_sequencer;

    localparam int WIDTH = 8;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] sw = '0;
    logic             next_p = 1'b0;
    logic             clr_p = 1'b0;
    logic             alu_done = 1'b0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [OPW-1:0]   opcode;
    logic             alu_start;
    logic             busy;
    logic [2:0]       phase;
    logic             err;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
    } exp_t;
    exp_t sb_q[$];

    alu_operand_sequencer #(
        .WIDTH      (WIDTH),
        .OPW        (OPW),
        .WAIT_LIMIT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .next_p    (next_p),
        .clr_p     (clr_p),
        .alu_done  (alu_done),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode    (opcode),
        .alu_start (alu_start),
        .busy      (busy),
        .phase     (phase),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every start pulse must match the oldest queued operand set.
    always @(negedge clk) begin
        if (!rst && alu_start === 1'b1) begin
            start_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("start_op_a", 32'(op_a), 32'(e.a));
                check("start_op_b", 32'(op_b), 32'(e.b));
                check("start_opcode", 32'(opcode), 32'(e.op));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] val);
        sw = val;
        next_p = 1'b1;
        tick();
        next_p = 1'b0;
    endtask

    task automatic done_pulse();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
    endtask

    // Three presses from GET_A; leaves the DUT in its ISSUE cycle.
    task automatic enter(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        press(a);
        press(b);
        sb_q.push_back({a, b, op});
        press({4'h0, op});
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Basic entry and issue.
        press(8'h3C);
        check("a_phase", 32'(phase), 32'd1);
        check("a_val", 32'(op_a), 32'h3C);
        press(8'h05);
        check("b_phase", 32'(phase), 32'd2);
        check("b_val", 32'(op_b), 32'h05);
        sb_q.push_back({8'h3C, 8'h05, 4'h2});
        press(8'h02);
        check("issue_phase", 32'(phase), 32'd3);
        check("issue_start", 32'(alu_start), 32'd1);
        check("issue_opcode", 32'(opcode), 32'h2);
        check("issue_busy", 32'(busy), 32'd1);
        tick();
        check("wait_phase", 32'(phase), 32'd4);
        check("wait_start", 32'(alu_start), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        tick();
        tick();
        done_pulse();
        check("show_phase", 32'(phase), 32'd5);
        check("show_busy", 32'(busy), 32'd0);
        check("start_count1", 32'(start_cnt), 32'd1);
        press(8'hAA);
        check("back_phase", 32'(phase), 32'd0);
        check("back_op_a", 32'(op_a), 32'h3C);

        // Presses during WAIT are ignored and not queued.
        enter(8'h11, 8'h22, 4'h3);
        tick();
        for (int i = 0; i < 5; i++) begin
            press(8'hFF);
            tick();
        end
        check("ign_phase", 32'(phase), 32'd4);
        check("ign_op_a", 32'(op_a), 32'h11);
        check("ign_op_b", 32'(op_b), 32'h22);
        check("ign_opcode", 32'(opcode), 32'h3);
        done_pulse();
        check("ign_show", 32'(phase), 32'd5);
        tick();
        tick();
        check("ign_stay", 32'(phase), 32'd5);
        check("start_count2", 32'(start_cnt), 32'd2);

        // Done outside WAIT (here SHOW) has no effect.
        done_pulse();
        check("done_in_show", 32'(phase), 32'd5);
        press(8'h00);

        // A done pulse during ISSUE is lost.
        enter(8'h9A, 8'hBC, 4'hD);
        done_pulse();
        check("done_in_issue", 32'(phase), 32'd4);
        done_pulse();
        check("done_after", 32'(phase), 32'd5);
        press(8'h00);

        // Clear and next together in GET_B.
        press(8'h44);
        check("gb_phase", 32'(phase), 32'd1);
        sw = 8'h77;
        next_p = 1'b1;
        clr_p = 1'b1;
        tick();
        next_p = 1'b0;
        clr_p = 1'b0;
        check("clr_phase", 32'(phase), 32'd0);
        check("clr_op_a", 32'(op_a), 32'd0);
        check("clr_op_b", 32'(op_b), 32'd0);
        check("clr_opcode", 32'(opcode), 32'd0);

        // Watchdog behaviour in WAIT with no done.
        enter(8'h01, 8'h02, 4'h4);
        tick();
`ifdef SEQ_WATCHDOG_EN
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("wd_last_wait", 32'(phase), 32'd4);
        check("wd_err_pre", 32'(err), 32'd0);
        tick();
        check("wd_phase", 32'(phase), 32'd5);
        check("wd_err", 32'(err), 32'd1);
        clr_p = 1'b1;
        tick();
        clr_p = 1'b0;
        check("wd_clr_err", 32'(err), 32'd0);
        check("wd_clr_phase", 32'(phase), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("nowd_phase", 32'(phase), 32'd4);
        check("nowd_err", 32'(err), 32'd0);
        clr_p = 1'b1;
        tick();
        clr_p = 1'b0;
        check("nowd_clr_phase", 32'(phase), 32'd0);
`endif

        // Reset while in WAIT aborts; a later done does nothing.
        enter(8'h55, 8'h66, 4'h7);
        tick();
        check("pre_rst_phase", 32'(phase), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(alu_start), 32'd0);
        check("mid_rst_op_a", 32'(op_a), 32'd0);
        check("mid_rst_opcode", 32'(opcode), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        done_pulse();
        tick();
        check("post_rst_done", 32'(phase), 32'd0);
        check("start_count_final", 32'(start_cnt), 32'd5);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
